// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/control unit for the 5-stage RV32I pipeline (ID stage): forwarding selects,
// load-use / RAW stalls, branch flush, multi-cycle EX stall and a stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned FWD_EN       = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MC_LAT       = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic [6:0]        id_opcode_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic              ex_mc_start_i,
    input  logic              br_taken_i,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              id_ex_en_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  perf_stall_cnt_o
);

    localparam int unsigned CntW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpS    = 7'b0100011;
    localparam logic [6:0] OpB    = 7'b1100011;
    localparam logic [6:0] OpLoad = 7'b0000011;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpJalr = 7'b1100111;

    typedef enum logic [1:0] {StRun, StMcWait, StFlush} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] perf_q, perf_d;

    logic use_rs1, use_rs2;
    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic dh;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_opcode_i)
            OpR, OpS, OpB: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OpLoad, OpImm, OpJalr: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // x0 is hardwired to zero, so it never creates a dependency.
    assign ex_hit_a  = use_rs1 & ex_regwrite_i & (ex_rd_i != '0) & (ex_rd_i == id_rs1_i);
    assign ex_hit_b  = use_rs2 & ex_regwrite_i & (ex_rd_i != '0) & (ex_rd_i == id_rs2_i);
    assign mem_hit_a = use_rs1 & mem_regwrite_i & (mem_rd_i != '0) & (mem_rd_i == id_rs1_i);
    assign mem_hit_b = use_rs2 & mem_regwrite_i & (mem_rd_i != '0) & (mem_rd_i == id_rs2_i);

    always_comb begin
        if (FWD_EN != 0) begin
            dh = ex_memread_i & (ex_hit_a | ex_hit_b);
        end else begin
            dh = ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b;
        end
    end

    always_comb begin
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    id_ex_en_o = 1'b1;
                    if (br_taken_i) begin
                        pc_en_o        = 1'b1;
                        if_id_en_o     = 1'b1;
                        if_id_flush_o  = 1'b1;
                        id_ex_bubble_o = 1'b1;
                    end else if (!ex_mc_start_i && dh) begin
                        id_ex_bubble_o = 1'b1;
                    end else begin
                        pc_en_o    = 1'b1;
                        if_id_en_o = 1'b1;
                    end
                end
                StFlush: begin
                    pc_en_o       = 1'b1;
                    if_id_en_o    = 1'b1;
                    id_ex_en_o    = 1'b1;
                    if_id_flush_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A bubbled/flushed ID/EX slot carries no operands, so its selects are cleared.
    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if ((FWD_EN != 0) && !id_ex_bubble_o && !if_id_flush_o) begin
            fwd_a_d = ex_hit_a ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00);
            fwd_b_d = ex_hit_b ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00);
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (!pc_en_o && (perf_q != '1)) begin
            perf_d = perf_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (br_taken_i) begin
                        if (FLUSH_CYCLES > 1) begin
                            state_q <= StFlush;
                            cnt_q   <= CntW'(FLUSH_CYCLES - 2);
                        end
                    end else if (ex_mc_start_i) begin
                        state_q <= StMcWait;
                        cnt_q   <= CntW'(MC_LAT - 2);
                    end
                end
                StMcWait, StFlush: begin
                    if (cnt_q == '0) begin
                        state_q <= StRun;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
            perf_q  <= '0;
        end else begin
            if (id_ex_en_o) begin
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
            perf_q <= perf_d;
        end
    end

    assign fwd_a_o          = fwd_a_q;
    assign fwd_b_o          = fwd_b_q;
    assign perf_stall_cnt_o = perf_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut_a uses default parameters, dut_b has FWD_EN=0, FLUSH_CYCLES=2 and a
// 2-bit counter so saturation is reachable. Both see the same stimulus.
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic       clk;
    logic       rst;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       ex_regwrite, ex_memread, mem_regwrite, ex_mc_start, br_taken;

    logic        a_pc_en, a_if_id_en, a_id_ex_en, a_flush, a_bubble;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [15:0] a_perf;
    logic        b_pc_en, b_if_id_en, b_id_ex_en, b_flush, b_bubble;
    logic [1:0]  b_fwd_a, b_fwd_b;
    logic [1:0]  b_perf;

    int n_run  = 0;
    int n_fail = 0;

    pipeline_hazard_ctrl dut_a (
        .clk_i(clk), .rst(rst), .id_opcode_i(id_opcode), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .ex_mc_start_i(ex_mc_start),
        .br_taken_i(br_taken), .pc_en_o(a_pc_en), .if_id_en_o(a_if_id_en),
        .id_ex_en_o(a_id_ex_en), .if_id_flush_o(a_flush), .id_ex_bubble_o(a_bubble),
        .fwd_a_o(a_fwd_a), .fwd_b_o(a_fwd_b), .perf_stall_cnt_o(a_perf)
    );

    pipeline_hazard_ctrl #(.FWD_EN(0), .FLUSH_CYCLES(2), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst(rst), .id_opcode_i(id_opcode), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .ex_mc_start_i(ex_mc_start),
        .br_taken_i(br_taken), .pc_en_o(b_pc_en), .if_id_en_o(b_if_id_en),
        .id_ex_en_o(b_id_ex_en), .if_id_flush_o(b_flush), .id_ex_bubble_o(b_bubble),
        .fwd_a_o(b_fwd_a), .fwd_b_o(b_fwd_b), .perf_stall_cnt_o(b_perf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        id_opcode = 7'd0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; mem_regwrite = 1'b0;
        ex_mc_start = 1'b0; br_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        set_idle();
        rst = 1'b1;
        #1;
        check_eq("rst_pc_en", a_pc_en, 0);
        check_eq("rst_if_id_en", a_if_id_en, 0);
        check_eq("rst_id_ex_en", a_id_ex_en, 0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("post_rst_pc_en", a_pc_en, 1);
        check_eq("post_rst_perf", a_perf, 0);
        check_eq("post_rst_fwd_a", a_fwd_a, 0);

        // Load-use on rs1
        id_opcode = OP_R; id_rs1 = 5; id_rs2 = 6;
        ex_rd = 5; ex_regwrite = 1'b1; ex_memread = 1'b1;
        #1;
        check_eq("lu_pc_en", a_pc_en, 0);
        check_eq("lu_if_id_en", a_if_id_en, 0);
        check_eq("lu_id_ex_en", a_id_ex_en, 1);
        check_eq("lu_bubble", a_bubble, 1);
        check_eq("lu_flush", a_flush, 0);
        tick();
        ex_rd = 0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5; mem_regwrite = 1'b1;
        #1;
        check_eq("lu_fwd_a_bubbled", a_fwd_a, 0);
        check_eq("lu_pc_en_resume", a_pc_en, 1);
        check_eq("lu_perf", a_perf, 1);
        tick();
        check_eq("lu_fwd_a_mem", a_fwd_a, 2);
        check_eq("lu_fwd_b", a_fwd_b, 0);

        // ALU forwarding, EX over MEM priority
        do_reset();
        id_opcode = OP_S; id_rs1 = 1; id_rs2 = 3; ex_rd = 3; ex_regwrite = 1'b1;
        #1;
        check_eq("alu_pc_en", a_pc_en, 1);
        check_eq("alu_bubble", a_bubble, 0);
        tick();
        check_eq("alu_fwd_b", a_fwd_b, 1);
        check_eq("alu_fwd_a", a_fwd_a, 0);
        id_opcode = OP_R; id_rs1 = 4; id_rs2 = 4; ex_rd = 4; mem_rd = 4; mem_regwrite = 1'b1;
        tick();
        check_eq("prio_fwd_a", a_fwd_a, 1);
        check_eq("prio_fwd_b", a_fwd_b, 1);

        // x0, unused sources, regwrite gating
        do_reset();
        id_opcode = OP_R; ex_regwrite = 1'b1; ex_memread = 1'b1;
        #1;
        check_eq("x0_pc_en", a_pc_en, 1);
        tick();
        check_eq("x0_fwd_a", a_fwd_a, 0);
        id_opcode = OP_LUI; id_rs1 = 5; id_rs2 = 5; ex_rd = 5; mem_rd = 5; mem_regwrite = 1'b1;
        #1;
        check_eq("lui_a_pc_en", a_pc_en, 1);
        check_eq("lui_b_pc_en", b_pc_en, 1);
        tick();
        check_eq("lui_fwd_a", a_fwd_a, 0);
        check_eq("lui_fwd_b", a_fwd_b, 0);
        id_opcode = OP_R; ex_regwrite = 1'b0; mem_regwrite = 1'b0;
        #1;
        check_eq("nowr_a_pc_en", a_pc_en, 1);
        check_eq("nowr_b_pc_en", b_pc_en, 1);

        // FWD_EN=0 stall on MEM match, counter saturation
        do_reset();
        id_opcode = OP_IMM; id_rs1 = 7; id_rs2 = 7; mem_rd = 7; mem_regwrite = 1'b1;
        #1;
        check_eq("nofwd_b_pc_en", b_pc_en, 0);
        check_eq("nofwd_b_bubble", b_bubble, 1);
        check_eq("nofwd_a_pc_en", a_pc_en, 1);
        tick();
        check_eq("nofwd_b_pc_en_hold", b_pc_en, 0);
        check_eq("nofwd_b_fwd_a", b_fwd_a, 0);
        check_eq("nofwd_a_fwd_a", a_fwd_a, 2);
        tick();
        check_eq("nofwd_b_perf2", b_perf, 2);
        tick(); tick(); tick();
        check_eq("perf_saturate", b_perf, 3);
        mem_regwrite = 1'b0;
        #1;
        check_eq("nofwd_b_release", b_pc_en, 1);

        // Multi-cycle op, MC_LAT=4
        do_reset();
        ex_mc_start = 1'b1;
        #1;
        check_eq("mc_start_pc_en", a_pc_en, 1);
        tick();
        ex_mc_start = 1'b0;
        #1;
        check_eq("mc_w1_pc_en", a_pc_en, 0);
        check_eq("mc_w1_id_ex_en", a_id_ex_en, 0);
        tick();
        check_eq("mc_w2_pc_en", a_pc_en, 0);
        tick();
        check_eq("mc_w3_id_ex_en", a_id_ex_en, 0);
        tick();
        check_eq("mc_done_pc_en", a_pc_en, 1);
        check_eq("mc_perf", a_perf, 3);
        ex_mc_start = 1'b1;
        tick();
        ex_mc_start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_eq("mc_rst_pc_en", a_pc_en, 0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("mc_abort_pc_en", a_pc_en, 1);
        check_eq("mc_abort_id_ex_en", a_id_ex_en, 1);
        check_eq("mc_abort_perf", a_perf, 0);

        // Branch flush, FLUSH_CYCLES=2 on dut_b, 1 on dut_a
        do_reset();
        br_taken = 1'b1;
        #1;
        check_eq("br_b_flush0", b_flush, 1);
        check_eq("br_b_bubble0", b_bubble, 1);
        check_eq("br_b_pc_en0", b_pc_en, 1);
        check_eq("br_a_flush0", a_flush, 1);
        tick();
        br_taken = 1'b0;
        #1;
        check_eq("br_b_flush1", b_flush, 1);
        check_eq("br_b_bubble1", b_bubble, 0);
        check_eq("br_b_pc_en1", b_pc_en, 1);
        check_eq("br_a_flush1", a_flush, 0);
        tick();
        check_eq("br_b_flush2", b_flush, 0);

        // Branch wins over a simultaneous multi-cycle start
        do_reset();
        br_taken = 1'b1; ex_mc_start = 1'b1;
        tick();
        br_taken = 1'b0; ex_mc_start = 1'b0;
        #1;
        check_eq("br_mc_pc_en", a_pc_en, 1);
        check_eq("br_mc_id_ex_en", a_id_ex_en, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
